sinegen_sweep_ctrl: RTL and testbench
=====================================

Name: sinegen_sweep_ctrl

Overview:
Sweep scheduler for the sine generator datapath. It sequences the counter increment (frequency word) and the phase offset presented to the sine generator through a programmed ramp-up, hold and ramp-down profile. Software or a top-level FSM supplies a one-shot configuration and a start pulse; this block then drives incr/phase_offset autonomously and reports busy/done.

Parameters:
A_WIDTH, 8, ROM address width; width of phase_offset and phase_base
D_WIDTH, 8, width of incr, incr_min, incr_max, step
DWELL_W, 16, width of the dwell and hold cycle counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a sweep (ignored while busy)
abort  input  1  terminate sweep and mute output
incr_min  input  D_WIDTH  sweep start/end increment
incr_max  input  D_WIDTH  sweep peak increment
step  input  D_WIDTH  increment change per step (0 treated as 1)
dwell  input  DWELL_W  cycles spent at each ramp value (0 treated as 1)
hold  input  DWELL_W  cycles spent at peak (0 treated as 1)
phase_base  input  A_WIDTH  phase offset applied during sweep
incr  output  D_WIDTH  registered increment to sine generator
phase_offset  output  A_WIDTH  registered phase offset to sine generator
busy  output  1  high in UP, HOLD, DOWN
done  output  1  one-cycle pulse on normal completion
state  output  2  IDLE=0, UP=1, HOLD=2, DOWN=3

Behaviour:
- Reset (async, immediate): incr=0, phase_offset=0, busy=0, done=0, state=IDLE, timer=0, shadow config=0.
- All outputs registered; done defaults low every cycle.
- Config (incr_min, incr_max, step, dwell, hold, phase_base) latched into shadow regs only on accepted start; later input changes have no effect mid-sweep.
- IDLE: start=1 and abort=0 -> next edge: incr=incr_min, phase_offset=phase_base, timer=0, busy=1; state=UP if incr_min<incr_max, else HOLD. incr holds last value while idle.
- UP: timer counts 0..dwell-1; at timer==dwell-1: timer=0; if (incr_max-incr)<=step (computed D_WIDTH+1 bits, no wrap) -> incr=incr_max, state=HOLD; else incr=incr+step.
- HOLD: timer counts 0..hold-1; at hold-1: timer=0, state=DOWN, incr unchanged.
- DOWN: timer counts 0..dwell-1; at dwell-1: if (incr-incr_min)<=step -> incr=incr_min, state=IDLE, busy=0, done=1 for one cycle; else incr=incr-step.
- incr never exceeds incr_max nor drops below incr_min during a sweep.
- abort: highest priority. In any non-IDLE state -> next edge state=IDLE, incr=0, phase_offset=0, busy=0, done=0. In IDLE with start same cycle: start ignored, incr=0.
- start while busy: ignored, no effect on timers or shadow regs.
- Reset asserted mid-sweep: outputs return to reset values without a clock edge; sweep not resumed after release.

Optional Feature:
PHASE_SWEEP_EN: adds input phase_step [A_WIDTH], latched at start. With macro: every UP incr update adds phase_step to phase_offset, every DOWN incr update subtracts it, modulo 2^A_WIDTH (wraps freely); HOLD leaves it unchanged. Without macro: port absent, phase_offset stays at phase_base for the whole sweep.

Test Plan:
- min=10,max=20,step=5,dwell=2,hold=3, start -> incr 10,10,15,15,20,20,20,20,20,15,15 then 10 with done=1 one cycle; busy high exactly 11 cycles.
- min=0,max=250,step=100,dwell=1 -> incr 0,100,200,250 (no overshoot/wrap), then 250 held, down 150,50,0, done.
- min=max=30, hold=2, dwell=1 -> state IDLE->HOLD directly, incr=30 for 3 cycles, done; step=0/dwell=0 with min=0,max=3 -> steps of 1 each cycle 0,1,2,3.
- abort during HOLD -> next cycle incr=0, phase_offset=0, busy=0, done never pulses; start+abort same cycle in IDLE -> stays IDLE.
- start re-pulsed and config inputs changed mid-UP -> sweep profile unchanged; async rst mid-UP -> incr=0, state=IDLE before next clk edge.
- PHASE_SWEEP_EN, phase_base=250, phase_step=4, min=0,max=8,step=4,dwell=1 -> phase_offset 250,254,2 (wrap), hold, then 254,250.

Source files
------------

// File: rtl/sinegen_sweep_ctrl.sv
// Sweep scheduler for the sine generator: steps the frequency word (incr)
// and phase offset through a ramp-up / hold / ramp-down profile after a
// start pulse, using a configuration captured when the sweep starts.
// Optional feature macro: PHASE_SWEEP_EN. When defined, it adds the
// phase_step input and ramps phase_offset together with incr.
module sinegen_sweep_ctrl #(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [D_WIDTH-1:0] incr_min,
  input  logic [D_WIDTH-1:0] incr_max,
  input  logic [D_WIDTH-1:0] step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [DWELL_W-1:0] hold,
  input  logic [A_WIDTH-1:0] phase_base,
`ifdef PHASE_SWEEP_EN
  input  logic [A_WIDTH-1:0] phase_step,
`endif
  output logic [D_WIDTH-1:0] incr,
  output logic [A_WIDTH-1:0] phase_offset,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_t;

  // Configuration captured on an accepted start. Zero step, dwell and hold
  // values are stored as 1.
  typedef struct packed {
    logic [D_WIDTH-1:0] incr_min;
    logic [D_WIDTH-1:0] incr_max;
    logic [D_WIDTH-1:0] step;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] hold;
`ifdef PHASE_SWEEP_EN
    logic [A_WIDTH-1:0] phase_step;
`endif
  } cfg_t;

  state_t             state_q;
  cfg_t               cfg;
  logic [DWELL_W-1:0] timer;

  logic [D_WIDTH:0]   up_gap_c;
  logic [D_WIDTH:0]   dn_gap_c;
  logic               up_last_c;
  logic               dn_last_c;
  logic               dwell_end_c;
  logic               hold_end_c;

  // The distance to the ramp end is computed one bit wider so the
  // comparison with step cannot wrap.
  assign up_gap_c    = {1'b0, cfg.incr_max} - {1'b0, incr};
  assign dn_gap_c    = {1'b0, incr} - {1'b0, cfg.incr_min};
  assign up_last_c   = (up_gap_c <= {1'b0, cfg.step});
  assign dn_last_c   = (dn_gap_c <= {1'b0, cfg.step});
  assign dwell_end_c = (timer == cfg.dwell - DWELL_W'(1));
  assign hold_end_c  = (timer == cfg.hold - DWELL_W'(1));

  assign state = state_q;

  // Sweep sequencer: state, timer, captured configuration and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cfg          <= '0;
      timer        <= '0;
      incr         <= '0;
      phase_offset <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort overrides everything and mutes the generator.
        state_q      <= IDLE;
        timer        <= '0;
        incr         <= '0;
        phase_offset <= '0;
        busy         <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              cfg.incr_min <= incr_min;
              cfg.incr_max <= incr_max;
              cfg.step     <= (step == '0) ? D_WIDTH'(1) : step;
              cfg.dwell    <= (dwell == '0) ? DWELL_W'(1) : dwell;
              cfg.hold     <= (hold == '0) ? DWELL_W'(1) : hold;
`ifdef PHASE_SWEEP_EN
              cfg.phase_step <= phase_step;
`endif
              incr         <= incr_min;
              phase_offset <= phase_base;
              timer        <= '0;
              busy         <= 1'b1;
              state_q      <= (incr_min < incr_max) ? UP : HOLD;
            end
          end

          UP: begin
            if (dwell_end_c) begin
              timer <= '0;
              if (up_last_c) begin
                incr    <= cfg.incr_max;
                state_q <= HOLD;
              end else begin
                incr <= incr + cfg.step;
              end
`ifdef PHASE_SWEEP_EN
              phase_offset <= phase_offset + cfg.phase_step;
`endif
            end else begin
              timer <= timer + DWELL_W'(1);
            end
          end

          HOLD: begin
            if (hold_end_c) begin
              timer   <= '0;
              state_q <= DOWN;
            end else begin
              timer <= timer + DWELL_W'(1);
            end
          end

          DOWN: begin
            if (dwell_end_c) begin
              timer <= '0;
              if (dn_last_c) begin
                incr    <= cfg.incr_min;
                state_q <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                incr <= incr - cfg.step;
              end
`ifdef PHASE_SWEEP_EN
              phase_offset <= phase_offset - cfg.phase_step;
`endif
            end else begin
              timer <= timer + DWELL_W'(1);
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sinegen_sweep_ctrl.sv
// Self-checking bench for sinegen_sweep_ctrl: directed profiles plus
// randomized start/abort/config traffic against a profile-level model.
module tb_sinegen_sweep_ctrl;

  localparam int unsigned A_WIDTH = 8;
  localparam int unsigned D_WIDTH = 8;
  localparam int unsigned DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [D_WIDTH-1:0] incr_min;
  logic [D_WIDTH-1:0] incr_max;
  logic [D_WIDTH-1:0] step;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] hold;
  logic [A_WIDTH-1:0] phase_base;
  logic [A_WIDTH-1:0] phase_step;
  logic [D_WIDTH-1:0] incr;
  logic [A_WIDTH-1:0] phase_offset;
  logic               busy;
  logic               done;
  logic [1:0]         state;

  sinegen_sweep_ctrl #(
    .A_WIDTH(A_WIDTH),
    .D_WIDTH(D_WIDTH),
    .DWELL_W(DWELL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .incr_min    (incr_min),
    .incr_max    (incr_max),
    .step        (step),
    .dwell       (dwell),
    .hold        (hold),
    .phase_base  (phase_base),
`ifdef PHASE_SWEEP_EN
    .phase_step  (phase_step),
`endif
    .incr        (incr),
    .phase_offset(phase_offset),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Expected post-edge values for one cycle.
  typedef struct {
    logic [7:0] incr;
    logic [7:0] phase;
    logic [1:0] st;
    logic       dn;
  } exp_t;

  exp_t prof[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_exp(input int v, input logic [7:0] ph, input logic [1:0] st, input logic dn);
    exp_t e;
    e.incr  = 8'(v);
    e.phase = ph;
    e.st    = st;
    e.dn    = dn;
    prof.push_back(e);
  endtask

  // Expand a whole sweep into its cycle-by-cycle expected outputs.
  task automatic build_profile(input int mn, input int mx, input int st_in, input int dw_in,
                               input int hd_in, input logic [7:0] pbase, input logic [7:0] pstep);
    int s, d, h, v;
    logic [7:0] ph;
    logic last;
    s  = (st_in == 0) ? 1 : st_in;
    d  = (dw_in == 0) ? 1 : dw_in;
    h  = (hd_in == 0) ? 1 : hd_in;
    v  = mn;
    ph = pbase;
    while (v < mx) begin
      repeat (d) push_exp(v, ph, 2'd1, 1'b0);
      v  = (mx - v <= s) ? mx : v + s;
      ph = ph + pstep;
    end
    repeat (h) push_exp(v, ph, 2'd2, 1'b0);
    last = 1'b0;
    while (!last) begin
      repeat (d) push_exp(v, ph, 2'd3, 1'b0);
      last = (v - mn <= s);
      v    = last ? mn : v - s;
      ph   = ph - pstep;
    end
    push_exp(v, ph, 2'd0, 1'b1);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step;
    logic [7:0] ps;
`ifdef PHASE_SWEEP_EN
    ps = phase_step;
`else
    ps = 8'd0;
`endif
    if (abort) begin
      prof.delete();
      cur.incr  = 8'd0;
      cur.phase = 8'd0;
      cur.st    = 2'd0;
      cur.dn    = 1'b0;
    end else if (prof.size() != 0) begin
      cur = prof.pop_front();
    end else if (start) begin
      build_profile(int'(incr_min), int'(incr_max), int'(step), int'(dwell), int'(hold),
                    phase_base, ps);
      cur = prof.pop_front();
    end else begin
      cur.dn = 1'b0;
    end
  endtask

  task automatic model_reset;
    prof.delete();
    cur.incr  = 8'd0;
    cur.phase = 8'd0;
    cur.st    = 2'd0;
    cur.dn    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_incr"}, 32'(incr), 32'(cur.incr));
    check({tag, "_phase"}, 32'(phase_offset), 32'(cur.phase));
    check({tag, "_state"}, 32'(state), 32'(cur.st));
    check({tag, "_busy"}, 32'(busy), 32'(cur.st != 2'd0));
    check({tag, "_done"}, 32'(done), 32'(cur.dn));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run_to_idle(input string tag, input int limit);
    int n = 0;
    while (prof.size() != 0 && n < limit) begin
      cycle(tag);
      n++;
    end
    check({tag, "_timeout"}, 32'(prof.size()), 32'd0);
  endtask

  task automatic set_cfg(input int mn, input int mx, input int st_in, input int dw, input int hd,
                         input int pb, input int ps);
    incr_min   = 8'(mn);
    incr_max   = 8'(mx);
    step       = 8'(st_in);
    dwell      = 16'(dw);
    hold       = 16'(hd);
    phase_base = 8'(pb);
    phase_step = 8'(ps);
  endtask

  int seq1[12];
  int seq2[8];
  int seq3[4];
  int seqp[7];
  int nbusy;
  int n;

  initial begin
    seq1 = '{10, 10, 15, 15, 20, 20, 20, 20, 20, 15, 15, 10};
    seq2 = '{0, 100, 200, 250, 250, 150, 50, 0};
    seq3 = '{0, 1, 2, 3};
    seqp = '{250, 254, 2, 2, 2, 254, 250};

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_all("reset");
    #9;
    rst = 1'b0;
    cycle("post_reset");

    // Basic ramp profile with dwell 2 and hold 3.
    set_cfg(10, 20, 5, 2, 3, 7, 0);
    start = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      cycle("t1");
      start = 1'b0;
      check("t1_seq", 32'(incr), 32'(seq1[i]));
      if (busy) nbusy++;
    end
    check("t1_done_last", 32'(done), 32'd1);
    check("t1_busy_cycles", 32'(nbusy), 32'd11);
    cycle("t1_after");
    check("t1_done_once", 32'(done), 32'd0);

    // Clamp at the top without wrapping.
    set_cfg(0, 250, 100, 1, 1, 0, 0);
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle("t2");
      start = 1'b0;
      check("t2_seq", 32'(incr), 32'(seq2[i]));
    end
    check("t2_done", 32'(done), 32'd1);

    // Equal bounds go straight to HOLD.
    set_cfg(30, 30, 5, 1, 2, 0, 0);
    start = 1'b1;
    cycle("t3");
    start = 1'b0;
    check("t3_direct_hold", 32'(state), 32'd2);
    run_to_idle("t3", 50);
    check("t3_end_incr", 32'(incr), 32'd30);

    // Zero step and dwell behave as 1.
    set_cfg(0, 3, 0, 0, 0, 0, 0);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle("t4");
      start = 1'b0;
      check("t4_seq", 32'(incr), 32'(seq3[i]));
    end
    run_to_idle("t4", 50);

    // Abort in HOLD.
    set_cfg(10, 20, 5, 2, 3, 9, 0);
    start = 1'b1;
    n = 0;
    do begin
      cycle("t5");
      start = 1'b0;
      n++;
    end while (state != 2'd2 && n < 40);
    check("t5_reached_hold", 32'(state), 32'd2);
    abort = 1'b1;
    cycle("t5_abort");
    abort = 1'b0;
    check("t5_muted", 32'(incr), 32'd0);
    repeat (12) cycle("t5_idle");

    // Start together with abort in IDLE.
    set_cfg(5, 50, 5, 1, 1, 3, 0);
    start = 1'b1;
    abort = 1'b1;
    cycle("t6");
    start = 1'b0;
    abort = 1'b0;
    check("t6_stays_idle", 32'(state), 32'd0);
    cycle("t6_idle");

    // Mid-sweep restarts and config changes have no effect.
    set_cfg(0, 250, 100, 1, 1, 0, 0);
    start = 1'b1;
    cycle("t7");
    for (int i = 1; i < 8; i++) begin
      set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 255),
               $urandom_range(0, 255));
      start = 1'b1;
      cycle("t7");
      check("t7_seq", 32'(incr), 32'(seq2[i]));
    end
    start = 1'b0;

    // Async reset mid-UP takes effect without a clock edge.
    set_cfg(0, 200, 10, 3, 1, 44, 0);
    start = 1'b1;
    cycle("t8");
    start = 1'b0;
    cycle("t8");
    cycle("t8");
    check("t8_in_up", 32'(state), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("t8_async");
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (3) cycle("t8_after");

`ifdef PHASE_SWEEP_EN
    // Phase ramp with modulo wrap.
    set_cfg(0, 8, 4, 1, 1, 250, 4);
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle("tp");
      start = 1'b0;
      check("tp_seq", 32'(phase_offset), 32'(seqp[i]));
    end
    check("tp_done", 32'(done), 32'd1);
`else
    // Phase offset stays at base throughout the sweep.
    set_cfg(0, 8, 4, 1, 1, 250, 4);
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle("tp");
      start = 1'b0;
      check("tp_base", 32'(phase_offset), 32'd250);
    end
`endif

    // Randomized traffic with config noise on every cycle.
    for (int i = 0; i < 6000; i++) begin
      set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 80),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255),
              $urandom_range(0, 255));
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 149) == 0);
      cycle("rnd");
    end
    start = 1'b0;
    abort = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
